exec_wb_seq: RTL and testbench
==============================

// Module: exec_wb_seq
// PURPOSE
//   Multi-cycle execute/writeback sequencer that sits directly in front of the 4x16 register file.
//   Accepts one 16-bit instruction per valid/ready handshake and drives the register file read
//   addresses (raA/raB). It captures rdA/rdB, computes the result (ALU or 16-step shift-add
//   multiply), and issues exactly one write (w/wa/wd) per writing instruction.
// PARAMETERS
//   DATA_W   16   datapath width; must match register file word width
// PORTS
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous, active-high reset
//   instr_valid  in   1       upstream has an instruction on instr
//   instr_ready  out  1       block can accept; high only in IDLE and not in reset
//   instr        in   16      [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6
//   raA          out  3       register file read address A (= rs1 of latched instr)
//   raB          out  3       register file read address B (= rs2 of latched instr)
//   rdA          in   DATA_W  register file read data A (combinational)
//   rdB          in   DATA_W  register file read data B (combinational)
//   w            out  1       register file write enable, one-cycle pulse
//   wa           out  3       register file write address (= rd)
//   wd           out  DATA_W  register file write data
//   busy         out  1       high in every state except IDLE
//   flag_z       out  1       zero flag
//   flag_c       out  1       carry/borrow flag
// BEHAVIOUR
//   Reset (synchronous): state IDLE; w=0; wa=0; wd=0; raA=raB=0; flag_z=flag_c=0; instr_ready=0
//     while reset is high. A reset in any state abandons the instruction; no write is issued.
//   States: IDLE -> READ -> EXEC -> WB -> IDLE. The MUL opcode uses READ -> MUL -> WB.
//   IDLE: instr_ready=1. On instr_valid&&instr_ready at edge T, latch instr and go to READ.
//   READ (T+1): raA/raB come from the latched fields. Capture rdA->opA and rdB->opB at the edge.
//   EXEC (T+2): compute result and next flags, registered at the edge.
//   WB (T+3): w=1, wa=rd, wd=result for one cycle. Return to IDLE; earliest next accept is edge T+4.
//   Ops:
//     0 ADD  opA+opB, C=carry-out
//     1 SUB  opA-opB, C=1 iff opA<opB unsigned
//     2 AND, 3 OR, 4 XOR
//     5 SHL  opA<<opB[3:0]
//     6 SHR  opA>>opB[3:0], logical
//     7 LDI  sign-extend imm6, no read use
//     8 MUL  low DATA_W bits of opA*opB
//     9 MOV  opA
//     10-15 NOP
//   Flags: updated at entry to WB.
//     flag_z = (result==0) for ops 0-9.
//     flag_c updated by ADD/SUB only; AND/OR/XOR clear C; all other ops leave C unchanged.
//   NOP: follows the READ/EXEC/WB timing, but w stays 0 in WB and flags are unchanged.
//   MUL: 16-iteration shift-add, iteration counter 0..15. One iteration per cycle in the MUL
//     state, cycles T+2..T+17. WB is at T+18. instr_ready stays 0 throughout.
//   Arithmetic: all ops are unsigned modulo 2^DATA_W. Shift amounts >= DATA_W yield 0.
//   Register indices 4-7: they read as 0 from the register file. Writes to them are still
//     pulsed, and the register file drops them.
//   Hazards: a write lands at the end of WB, and the next instruction's READ is at least 2 cycles
//     later, so back-to-back dependent instructions see updated data. No forwarding is needed.
//   instr is sampled only at the handshake edge; changes while busy are ignored.
//   w is never high outside WB. w is never high for two consecutive cycles.
// TESTING
//   1. Reset, then LDI r1,#-3 (instr=0x723D) -> w=1 in cycle T+3, wa=1, wd=0xFFFD, Z=0.
//   2. ADD r2,r1,r1 with r1=0xFFFD -> wd=0xFFFA, wa=2, flag_c=1, flag_z=0.
//   3. SUB r3,r1,r1 -> wd=0x0000, wa=3, flag_z=1, flag_c=0.
//   4. MUL r0,r1,r2 with r1=3, r2=5 -> instr_ready=0 for cycles T+1..T+18; w=1 only at T+18; wd=0x000F, wa=0.
//   5. instr_valid held high with 3 back-to-back ADDs -> accepts at edges T, T+4, T+8; exactly 3 w pulses.
//   6. Reset asserted in MUL iteration 8 -> no w pulse, busy=0 next cycle, flags=0, and the next instr is accepted normally.
//   7. Opcode 0xF -> no w pulse, busy for 3 cycles, flags unchanged.

Source files
------------

// File: rtl/exec_wb_seq.sv
// Execute/writeback sequencer in front of a 4x16 register file.
// One instruction per handshake: READ -> EXEC (or 16-cycle MUL) -> WB, one write per result.
module exec_wb_seq #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [2:0]        raA,
    output logic [2:0]        raB,
    input  logic [DATA_W-1:0] rdA,
    input  logic [DATA_W-1:0] rdB,
    output logic              w,
    output logic [2:0]        wa,
    output logic [DATA_W-1:0] wd,
    output logic              busy,
    output logic              flag_z,
    output logic              flag_c
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] READ = 3'd1;
    localparam logic [2:0] EXEC = 3'd2;
    localparam logic [2:0] MULS = 3'd3;
    localparam logic [2:0] WB   = 3'd4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_LDI = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;

    logic [2:0]        state;
    logic [15:0]       instrQ;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] acc;
    logic [3:0]        mulCnt;
    logic [DATA_W:0]   aluOut;
    logic [DATA_W-1:0] mulSum;
    logic [3:0]        op;
    logic [2:0]        rd;

    function automatic logic [DATA_W-1:0] shiftOp(input logic [DATA_W-1:0] a,
                                                  input logic [3:0] amt,
                                                  input logic left);
        if (32'(amt) >= DATA_W) return '0;
        return left ? (a << amt) : (a >> amt);
    endfunction

    // Bit DATA_W carries carry-out for ADD and borrow for SUB; zero otherwise.
    function automatic logic [DATA_W:0] aluCalc(input logic [3:0] o,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [5:0] imm);
        logic [DATA_W:0] r;
        r = '0;
        case (o)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SHL:  r = {1'b0, shiftOp(a, b[3:0], 1'b1)};
            OP_SHR:  r = {1'b0, shiftOp(a, b[3:0], 1'b0)};
            OP_LDI:  r = {1'b0, {{(DATA_W-6){imm[5]}}, imm}};
            OP_MOV:  r = {1'b0, a};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign op          = instrQ[15:12];
    assign rd          = instrQ[11:9];
    assign raA         = instrQ[8:6];
    assign raB         = instrQ[5:3];
    assign busy        = (state != IDLE);
    assign instr_ready = (state == IDLE) && !reset;

    always_comb begin
        aluOut = aluCalc(op, opA, opB, instrQ[5:0]);
        mulSum = acc + (opB[0] ? opA : '0);
    end

    // Control path: sequencing, write strobe and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            instrQ <= '0;
            mulCnt <= '0;
            w      <= 1'b0;
            wa     <= '0;
            wd     <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            w <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instrQ <= instr;
                        state  <= READ;
                    end
                end
                READ: begin
                    mulCnt <= '0;
                    state  <= (op == OP_MUL) ? MULS : EXEC;
                end
                EXEC: begin
                    state <= WB;
                    if (op <= OP_MOV) begin
                        w      <= 1'b1;
                        wa     <= rd;
                        wd     <= aluOut[DATA_W-1:0];
                        flag_z <= (aluOut[DATA_W-1:0] == '0);
                        if (op == OP_ADD || op == OP_SUB)
                            flag_c <= aluOut[DATA_W];
                        else if (op == OP_AND || op == OP_OR || op == OP_XOR)
                            flag_c <= 1'b0;
                    end
                end
                MULS: begin
                    mulCnt <= mulCnt + 4'd1;
                    if (mulCnt == 4'd15) begin
                        state  <= WB;
                        w      <= 1'b1;
                        wa     <= rd;
                        wd     <= mulSum;
                        flag_z <= (mulSum == '0);
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Data path: operand capture and shift-add multiply (multiplicand left, multiplier right).
    always_ff @(posedge clk) begin
        case (state)
            READ: begin
                opA <= rdA;
                opB <= rdB;
                acc <= '0;
            end
            MULS: begin
                acc <= mulSum;
                opA <= opA << 1;
                opB <= opB >> 1;
            end
            default: begin
                opA <= opA;
                opB <= opB;
                acc <= acc;
            end
        endcase
    end

endmodule

// File: tb/tb_exec_wb_seq.sv
// Bench for exec_wb_seq: register file model, scoreboard of expected writes, directed steps.
module tb_exec_wb_seq;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              instr_valid = 1'b0;
    logic [15:0]       instr = 16'h0;
    logic              instr_ready;
    logic [2:0]        raA, raB, wa;
    logic [DATA_W-1:0] rdA, rdB, wd;
    logic              w, busy, flag_z, flag_c;

    always #5 clk = ~clk;

    exec_wb_seq #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .raA(raA), .raB(raB), .rdA(rdA), .rdB(rdB), .w(w), .wa(wa), .wd(wd),
        .busy(busy), .flag_z(flag_z), .flag_c(flag_c)
    );

    // Environment register file: indices 4-7 read as zero, writes to them are dropped.
    logic [DATA_W-1:0] rf [0:3] = '{16'h0, 16'h0, 16'h0, 16'h0};
    assign rdA = (raA < 3'd4) ? rf[raA[1:0]] : '0;
    assign rdB = (raB < 3'd4) ? rf[raB[1:0]] : '0;
    always @(posedge clk) if (w && wa < 3'd4) rf[wa[1:0]] <= wd;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]        wa;
        logic [DATA_W-1:0] wd;
        int                at;
    } exp_t;
    exp_t sbq[$];

    int nCmp = 0, nErr = 0, wCount = 0, acceptCyc = 0;
    logic wPrev = 1'b0;

    // Reference state, advanced in instruction order when stimulus is issued.
    logic [DATA_W-1:0] mdl [0:3] = '{16'h0, 16'h0, 16'h0, 16'h0};
    logic mz = 1'b0, mc = 1'b0;

    logic [15:0] tbl [0:11] = '{16'h723F, 16'h740F, 16'h2650, 16'h3650, 16'h4650, 16'h5650,
                                16'h6650, 16'h9640, 16'h1688, 16'h0708, 16'h7A01, 16'h8448};

    always @(negedge clk) begin
        if (w) begin
            wCount++;
            nCmp++;
            assert (wPrev === 1'b0) else begin nErr++; $error("FAIL w_double observed=%b expected=0", wPrev); end
            nCmp++;
            assert (busy === 1'b1) else begin nErr++; $error("FAIL w_busy observed=%b expected=1", busy); end
        end
        if (w || (sbq.size() != 0 && cyc >= sbq[0].at)) begin
            nCmp++;
            assert (sbq.size() != 0) else begin nErr++; $error("FAIL w_unexpected wa=%0d wd=%h expected no write", wa, wd); end
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                nCmp++;
                assert (w === 1'b1 && cyc == e.at) else begin
                    nErr++; $error("FAIL wb_timing observed w=%b cyc=%0d expected w=1 cyc=%0d", w, cyc, e.at);
                end
                if (w) begin
                    nCmp++;
                    assert (wa === e.wa) else begin nErr++; $error("FAIL wb_wa observed=%0d expected=%0d", wa, e.wa); end
                    nCmp++;
                    assert (wd === e.wd) else begin nErr++; $error("FAIL wb_wd observed=%h expected=%h", wd, e.wd); end
                end
            end
        end
        wPrev = w;
    end

    function automatic logic [DATA_W-1:0] rdModel(input logic [2:0] idx);
        return (idx < 3'd4) ? mdl[idx[1:0]] : '0;
    endfunction

    task automatic modelExec(input logic [15:0] ins, output logic wr,
                             output logic [DATA_W-1:0] res, output int lat);
        logic [3:0]        o;
        logic [2:0]        rdi;
        logic [DATA_W-1:0] a, b;
        logic [DATA_W:0]   s;
        logic [31:0]       prod;
        o = ins[15:12]; rdi = ins[11:9];
        a = rdModel(ins[8:6]); b = rdModel(ins[5:3]);
        wr = 1'b1; lat = 3; res = '0;
        case (o)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; res = s[DATA_W-1:0]; mc = s[DATA_W]; end
            4'd1: begin res = a - b; mc = (a < b); end
            4'd2: begin res = a & b; mc = 1'b0; end
            4'd3: begin res = a | b; mc = 1'b0; end
            4'd4: begin res = a ^ b; mc = 1'b0; end
            4'd5: res = a << b[3:0];
            4'd6: res = a >> b[3:0];
            4'd7: res = {{(DATA_W-6){ins[5]}}, ins[5:0]};
            4'd8: begin prod = a * b; res = prod[DATA_W-1:0]; lat = 18; end
            4'd9: res = a;
            default: wr = 1'b0;
        endcase
        if (wr) begin
            mz = (res == '0);
            if (rdi < 3'd4) mdl[rdi[1:0]] = res;
        end
    endtask

    task automatic issue(input logic [15:0] ins, input bit commit, input bit keepValid);
        logic wr;
        logic [DATA_W-1:0] res;
        int lat, waitc;
        exp_t e;
        @(negedge clk);
        instr = ins; instr_valid = 1'b1; waitc = 0;
        while (instr_ready !== 1'b1 && waitc < 100) begin @(negedge clk); waitc++; end
        nCmp++;
        assert (instr_ready === 1'b1) else begin nErr++; $error("FAIL accept_timeout ins=%h ready=%b expected=1", ins, instr_ready); end
        acceptCyc = cyc;
        if (commit) begin
            modelExec(ins, wr, res, lat);
            if (wr) begin e.wa = ins[11:9]; e.wd = res; e.at = cyc + lat; sbq.push_back(e); end
        end
        @(posedge clk); #1;
        if (!keepValid) instr_valid = 1'b0;
    endtask

    task automatic drain();
        int waitc;
        instr_valid = 1'b0; waitc = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || sbq.size() != 0) && waitc < 100) begin @(negedge clk); waitc++; end
        nCmp++;
        assert (busy === 1'b0 && sbq.size() == 0) else begin
            nErr++; $error("FAIL drain_timeout busy=%b pending=%0d expected 0/0", busy, sbq.size());
        end
    endtask

    task automatic checkFlags(input string tag);
        nCmp++;
        assert (flag_z === mz) else begin nErr++; $error("FAIL %s_z observed=%b expected=%b", tag, flag_z, mz); end
        nCmp++;
        assert (flag_c === mc) else begin nErr++; $error("FAIL %s_c observed=%b expected=%b", tag, flag_c, mc); end
    endtask

    task automatic checkBusy(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            nCmp++;
            assert (busy === 1'b1 && instr_ready === 1'b0) else begin
                nErr++; $error("FAIL busy_c%0d observed busy=%b ready=%b expected 1/0", k, busy, instr_ready);
            end
        end
        @(negedge clk);
        nCmp++;
        assert (busy === 1'b0 && instr_ready === 1'b1) else begin
            nErr++; $error("FAIL busy_end observed busy=%b ready=%b expected 0/1", busy, instr_ready);
        end
    endtask

    initial begin
        int a0, w0, waitc;

        // Reset state
        repeat (3) @(negedge clk);
        nCmp++;
        assert (instr_ready === 1'b0 && busy === 1'b0 && w === 1'b0) else begin
            nErr++; $error("FAIL rst_ctrl observed ready=%b busy=%b w=%b expected 0/0/0", instr_ready, busy, w);
        end
        nCmp++;
        assert (wa === 3'd0 && wd === 16'h0 && raA === 3'd0 && raB === 3'd0) else begin
            nErr++; $error("FAIL rst_data observed wa=%0d wd=%h raA=%0d raB=%0d expected 0", wa, wd, raA, raB);
        end
        checkFlags("rst");
        reset = 1'b0;

        // LDI, ADD with carry, SUB to zero
        issue(16'h723D, 1, 0); drain(); checkFlags("ldi");
        issue(16'h0448, 1, 0); drain(); checkFlags("add");
        issue(16'h1648, 1, 0); drain(); checkFlags("sub");

        // MUL 3*5 with ready low for the whole sequence
        issue(16'h7203, 1, 0); drain();
        issue(16'h7405, 1, 0); drain();
        issue(16'h8050, 1, 0); checkBusy(18); drain(); checkFlags("mul");

        // Back-to-back ADDs with valid held high
        w0 = wCount;
        issue(16'h0650, 1, 1); a0 = acceptCyc;
        issue(16'h06C8, 1, 1);
        nCmp++;
        assert (acceptCyc - a0 == 4) else begin nErr++; $error("FAIL b2b_2 observed=%0d expected=4", acceptCyc - a0); end
        issue(16'h00D8, 1, 1);
        nCmp++;
        assert (acceptCyc - a0 == 8) else begin nErr++; $error("FAIL b2b_3 observed=%0d expected=8", acceptCyc - a0); end
        drain();
        nCmp++;
        assert (wCount - w0 == 3) else begin nErr++; $error("FAIL b2b_pulses observed=%0d expected=3", wCount - w0); end
        checkFlags("b2b");

        // Logic/shift/move ops, borrow, high register indices, large MUL
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i], 1, 0); drain(); checkFlags("tbl");
        end
        issue(16'h0650, 1, 0); drain(); checkFlags("wrap");

        // NOPs leave flags alone and never write
        issue(16'hF000, 1, 0); checkBusy(3); drain(); checkFlags("nop");
        issue(16'hA123, 1, 0); drain(); checkFlags("nop2");

        // Reset during MUL iteration 8 abandons the instruction
        issue(16'h8448, 0, 0);
        waitc = 0;
        while (cyc < acceptCyc + 10 && waitc < 50) begin @(negedge clk); waitc++; end
        nCmp++;
        assert (busy === 1'b1) else begin nErr++; $error("FAIL mulrst_busy observed=%b expected=1", busy); end
        reset = 1'b1;
        @(negedge clk);
        nCmp++;
        assert (busy === 1'b0 && w === 1'b0 && instr_ready === 1'b0) else begin
            nErr++; $error("FAIL mulrst_ctrl observed busy=%b w=%b ready=%b expected 0/0/0", busy, w, instr_ready);
        end
        mz = 1'b0; mc = 1'b0;
        checkFlags("mulrst");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        issue(16'h7A3E, 1, 0); drain(); checkFlags("postrst");
        issue(16'h0448, 1, 0); drain(); checkFlags("postrst_add");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
